modulo_mux: RTL and testbench

Registered 2:1 selector. Routes input `uno` (when `sel`=1) or input `cero` (when `sel`=0) to output `Q`, one clock after sampling. It also tracks select-line activity, with a one-cycle toggle pulse and a saturating toggle counter. It is used as a leaf datapath element wherever a clean, reset-defined, glitch-free selected value is required.

---
 rtl/modulo_mux_pkg.sv | 10 +
 rtl/modulo_mux_mux2.sv | 16 +
 rtl/modulo_mux.sv | 62 ++++++
 tb/tb_modulo_mux.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/modulo_mux_pkg.sv
// Shared constants for the registered 2:1 selector (modulo_mux) and its combinational core.
package modulo_mux_pkg;

  localparam int DEF_WIDTH = 1;
  localparam int DEF_CNT_W = 8;

  localparam logic SEL_CERO = 1'b0;
  localparam logic SEL_UNO  = 1'b1;

endpackage

// File: rtl/modulo_mux_mux2.sv
// mux2_comb: purely combinational WIDTH-bit 2:1 selector (sel=1 picks uno, sel=0 picks cero).
module mux2_comb
  import modulo_mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] uno,
  input  logic [WIDTH-1:0] cero,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  // A continuous assign has no path that leaves y unassigned, so no latch can form.
  assign y = (sel == SEL_UNO) ? uno : cero;

endmodule

// File: rtl/modulo_mux.sv
// modulo_mux: registered 2:1 selector with select-toggle pulse and saturating toggle counter.
// Optional registered even-parity output Q_par when MODULO_MUX_PARITY_EN is defined.
module modulo_mux
  import modulo_mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] uno,
  input  logic [WIDTH-1:0] cero,
  input  logic             sel,
  output logic [WIDTH-1:0] Q,
  output logic             sel_q,
  output logic             sel_toggle,
  output logic [CNT_W-1:0] toggle_cnt
`ifdef MODULO_MUX_PARITY_EN
  ,
  output logic             Q_par
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] mux_y;
  logic             toggle;

  mux2_comb #(.WIDTH(WIDTH)) u_mux2 (
    .uno  (uno),
    .cero (cero),
    .sel  (sel),
    .y    (mux_y)
  );

  // sel_q doubles as the previous select sample; its reset value 0 is the first reference.
  assign toggle = (sel != sel_q);

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      Q          <= '0;
      sel_q      <= SEL_CERO;
      sel_toggle <= 1'b0;
      toggle_cnt <= '0;
    end else begin
      Q          <= mux_y;
      sel_q      <= sel;
      sel_toggle <= toggle;
      if (toggle && (toggle_cnt != CNT_MAX))
        toggle_cnt <= toggle_cnt + CNT_W'(1);
    end
  end

`ifdef MODULO_MUX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) Q_par <= 1'b0;
    else     Q_par <= ^mux_y;
  end
`endif

endmodule

// File: tb/tb_modulo_mux.sv
// Self-checking bench for modulo_mux: default-width instance driven from a vector table,
// plus a WIDTH=4/CNT_W=2 instance for saturation, mid-run reset and parity sequences.
module tb_modulo_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default configuration (WIDTH=1, CNT_W=8)
  logic       rst_a, uno_a, cero_a, sel_a;
  logic       q_a, sel_q_a, sel_toggle_a;
  logic [7:0] cnt_a;
  // Instance B: WIDTH=4, CNT_W=2
  logic       rst_b, sel_b;
  logic [3:0] uno_b, cero_b, q_b;
  logic       sel_q_b, sel_toggle_b;
  logic [1:0] cnt_b;
`ifdef MODULO_MUX_PARITY_EN
  logic       par_a, par_b;
`endif

  modulo_mux dut_a (
    .clk(clk), .rst(rst_a), .uno(uno_a), .cero(cero_a), .sel(sel_a),
    .Q(q_a), .sel_q(sel_q_a), .sel_toggle(sel_toggle_a), .toggle_cnt(cnt_a)
`ifdef MODULO_MUX_PARITY_EN
    , .Q_par(par_a)
`endif
  );

  modulo_mux #(.WIDTH(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst_b), .uno(uno_b), .cero(cero_b), .sel(sel_b),
    .Q(q_b), .sel_q(sel_q_b), .sel_toggle(sel_toggle_b), .toggle_cnt(cnt_b)
`ifdef MODULO_MUX_PARITY_EN
    , .Q_par(par_b)
`endif
  );

  typedef struct packed {
    logic       rst;
    logic       uno;
    logic       cero;
    logic       sel;
    logic       q;
    logic       sq;
    logic       tg;
    logic [7:0] cnt;
  } vec_t;

  typedef struct packed {
    logic [3:0] q;
    logic       sq;
    logic       tg;
    logic [7:0] cnt;
    logic       par;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic pop_exp(input string tag, output exp_t e, output bit ok);
    ok = 1'b1;
    e  = '0;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      ok = 1'b0;
      $display("FAIL %s scoreboard empty actual=0 expected=1", tag);
    end else begin
      e = sb.pop_front();
    end
  endtask

  task automatic apply_a(input string tag, input vec_t v);
    exp_t e;
    bit   ok;
    @(negedge clk);
    rst_a = v.rst; uno_a = v.uno; cero_a = v.cero; sel_a = v.sel;
    sb.push_back('{q: {3'b0, v.q}, sq: v.sq, tg: v.tg, cnt: v.cnt, par: v.q});
    @(posedge clk);
    #1;
    pop_exp(tag, e, ok);
    if (ok) begin
      check({tag, ".Q"},          32'(q_a),          32'(e.q));
      check({tag, ".sel_q"},      32'(sel_q_a),      32'(e.sq));
      check({tag, ".sel_toggle"}, 32'(sel_toggle_a), 32'(e.tg));
      check({tag, ".toggle_cnt"}, 32'(cnt_a),        32'(e.cnt));
`ifdef MODULO_MUX_PARITY_EN
      check({tag, ".Q_par"},      32'(par_a),        32'(e.par));
`endif
    end
  endtask

  // Expected Q and parity come from a small model; sel_q/toggle/count are given by the caller.
  task automatic apply_b(input string tag, input logic r, input logic [3:0] u, input logic [3:0] c,
                         input logic s, input logic sq, input logic tg, input logic [1:0] cnt);
    exp_t       e;
    bit         ok;
    logic [3:0] mq;
    @(negedge clk);
    rst_b = r; uno_b = u; cero_b = c; sel_b = s;
    mq = r ? 4'b0 : (s ? u : c);
    sb.push_back('{q: mq, sq: sq, tg: tg, cnt: {6'b0, cnt}, par: ^mq});
    @(posedge clk);
    #1;
    pop_exp(tag, e, ok);
    if (ok) begin
      check({tag, ".Q"},          32'(q_b),          32'(e.q));
      check({tag, ".sel_q"},      32'(sel_q_b),      32'(e.sq));
      check({tag, ".sel_toggle"}, 32'(sel_toggle_b), 32'(e.tg));
      check({tag, ".toggle_cnt"}, 32'(cnt_b),        32'(e.cnt));
`ifdef MODULO_MUX_PARITY_EN
      check({tag, ".Q_par"},      32'(par_b),        32'(e.par));
`endif
    end
  endtask

  vec_t vecs[11];

  initial begin
    rst_a = 1'b1; uno_a = 1'b0; cero_a = 1'b0; sel_a = 1'b0;
    rst_b = 1'b1; uno_b = 4'h0; cero_b = 4'h0; sel_b = 1'b0;

    //           rst   uno   cero  sel   Q     sel_q tog   cnt
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};  // reset cycle 1
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};  // reset cycle 2
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1};  // select uno
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2};  // select cero
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2};  // equal inputs
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2};  // equal inputs held
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd3};  // uno=0 selected
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3};  // sel held high
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};  // mid-run reset
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1};  // first edge after reset
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1};  // steady

    for (int i = 0; i < 11; i++)
      apply_a($sformatf("a_vec%0d", i), vecs[i]);

    // Saturation with CNT_W=2: sel toggles every cycle
    apply_b("b_rst", 1'b1, 4'b1011, 4'b0110, 1'b0, 1'b0, 1'b0, 2'd0);
    apply_b("b_sat0", 1'b0, 4'b1011, 4'b0110, 1'b1, 1'b1, 1'b1, 2'd1);
    apply_b("b_sat1", 1'b0, 4'b1011, 4'b0110, 1'b0, 1'b0, 1'b1, 2'd2);
    apply_b("b_sat2", 1'b0, 4'b1011, 4'b0110, 1'b1, 1'b1, 1'b1, 2'd3);
    apply_b("b_sat3", 1'b0, 4'b1011, 4'b0110, 1'b0, 1'b0, 1'b1, 2'd3);
    apply_b("b_sat4", 1'b0, 4'b1011, 4'b0110, 1'b1, 1'b1, 1'b1, 2'd3);
    apply_b("b_sat5", 1'b0, 4'b1011, 4'b0110, 1'b0, 1'b0, 1'b1, 2'd3);
    // Reset asserted mid-run with sel still toggling
    apply_b("b_midrst", 1'b1, 4'b1011, 4'b0110, 1'b1, 1'b0, 1'b0, 2'd0);
    // Parity sequence
    apply_b("b_par_uno",  1'b0, 4'b1011, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd1);
    apply_b("b_par_cero", 1'b0, 4'b1011, 4'b0110, 1'b0, 1'b0, 1'b1, 2'd2);
    apply_b("b_hold",     1'b0, 4'b0001, 4'b1110, 1'b0, 1'b0, 1'b0, 2'd2);

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
